// File: rtl/wb_seq_pkg.sv
// Shared opcodes, FSM states and command-word layout for the Wishbone sequencing master.
// Command word is packed as {op, adr, dat, msk} with msk in the low bits.
package wb_seq_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned DLY_W = 16;

  localparam logic [OP_W-1:0] OP_WRITE = 2'd0;
  localparam logic [OP_W-1:0] OP_READ  = 2'd1;
  localparam logic [OP_W-1:0] OP_POLL  = 2'd2;
  localparam logic [OP_W-1:0] OP_DELAY = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DLY   = 2'd3
  } state_e;

  function automatic int unsigned cmd_w(int unsigned aw, int unsigned dw);
    return OP_W + aw + 2 * dw;
  endfunction

  function automatic int unsigned msk_lsb();
    return 0;
  endfunction

  function automatic int unsigned dat_lsb(int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned adr_lsb(int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned op_lsb(int unsigned aw, int unsigned dw);
    return 2 * dw + aw;
  endfunction

endpackage

// File: rtl/wb_seq_fifo.sv
// Synchronous command FIFO; full/empty flags are registered alongside the occupancy count.
module wb_seq_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            full_q, empty_q;
  logic            do_push, do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push_i & ~full_q;
    do_pop  = pop_i & ~empty_q;
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    cnt_d   = cnt_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNTW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/wb_seq_master.sv
// Command-driven single-beat Wishbone master: queued WRITE/READ/POLL/DELAY with one
// response per command, bus timeout and bounded poll retries.
module wb_seq_master
  import wb_seq_pkg::*;
#(
  parameter int unsigned AW       = 2,
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned POLL_MAX = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [DW-1:0] cmd_dat_i,
  input  logic [DW-1:0] cmd_msk_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  output logic          busy_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic [AW-1:0] adr_o,
  output logic          wnr_o,
  output logic [DW-1:0] dat_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i
);

  localparam int unsigned CW  = cmd_w(AW, DW);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam int unsigned AC  = $clog2(POLL_MAX + 1);
  localparam int unsigned MSK = msk_lsb();
  localparam int unsigned DAT = dat_lsb(DW);
  localparam int unsigned ADR = adr_lsb(DW);
  localparam int unsigned OPL = op_lsb(AW, DW);

  logic [CW-1:0]   push_word, head;
  logic            fifo_full, fifo_empty, push_c, pop_c;
  logic [OP_W-1:0] head_op;
  logic [AW-1:0]   head_adr;
  logic [DW-1:0]   head_dat, head_msk;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            wnr_q, wnr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW-1:0]   msk_q, msk_d;
  logic            stb_q, stb_d;
  logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [AC-1:0]   att_q, att_d, att_inc;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic            poll_miss;

  assign push_word = {cmd_op_i, cmd_adr_i, cmd_dat_i, cmd_msk_i};
  assign push_c    = cmd_valid_i & ~fifo_full;
  assign head_op   = head[OPL +: OP_W];
  assign head_adr  = head[ADR +: AW];
  assign head_dat  = head[DAT +: DW];
  assign head_msk  = head[MSK +: DW];

  wb_seq_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (push_word),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tmo_inc   = tmo_q + TW'(1);
  assign att_inc   = att_q + AC'(1);
  assign poll_miss = (op_q == OP_POLL) && (((dat_i ^ dat_q) & msk_q) != '0);

  // Next-state and bus/response outputs; ack wins over a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    adr_d       = adr_q;
    wnr_d       = wnr_q;
    wdat_d      = wdat_q;
    dat_d       = dat_q;
    msk_d       = msk_q;
    stb_d       = stb_q;
    tmo_d       = tmo_q;
    att_d       = att_q;
    dly_d       = dly_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = '0;
    rsp_err_d   = 1'b0;
    pop_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c  = 1'b1;
          op_d   = head_op;
          adr_d  = head_adr;
          wnr_d  = (head_op == OP_WRITE);
          wdat_d = (head_op == OP_WRITE) ? head_dat : '0;
          dat_d  = head_dat;
          msk_d  = head_msk;
          tmo_d  = '0;
          att_d  = '0;
          if (head_op == OP_DELAY) begin
            state_d = DLY;
            dly_d   = DLY_W'(head_dat);
          end else begin
            state_d = ISSUE;
            stb_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (stb_q && ack_i) begin
          stb_d = 1'b0;
          if (poll_miss) begin
            att_d = att_inc;
            if (att_inc < AC'(POLL_MAX)) begin
              state_d = GAP;
            end else begin
              state_d     = IDLE;
              rsp_valid_d = 1'b1;
              rsp_dat_d   = dat_i;
              rsp_err_d   = 1'b1;
            end
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_dat_d   = (op_q == OP_WRITE) ? '0 : dat_i;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TW'(TIMEOUT)) begin
            stb_d       = 1'b0;
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      GAP: begin
        stb_d   = 1'b1;
        tmo_d   = '0;
        state_d = ISSUE;
      end
      DLY: begin
        if (dly_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= '0;
      adr_q       <= '0;
      wnr_q       <= 1'b0;
      wdat_q      <= '0;
      dat_q       <= '0;
      msk_q       <= '0;
      stb_q       <= 1'b0;
      tmo_q       <= '0;
      att_q       <= '0;
      dly_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      adr_q       <= adr_d;
      wnr_q       <= wnr_d;
      wdat_q      <= wdat_d;
      dat_q       <= dat_d;
      msk_q       <= msk_d;
      stb_q       <= stb_d;
      tmo_q       <= tmo_d;
      att_q       <= att_d;
      dly_q       <= dly_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = ~fifo_full;
  assign busy_o      = (state_q != IDLE) | ~fifo_empty;
  assign stb_o       = stb_q;
  assign cyc_o       = stb_q;
  assign adr_o       = adr_q;
  assign wnr_o       = wnr_q;
  assign dat_o       = wdat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_seq_master.sv
// Directed bench for wb_seq_master: single-command vector table plus hand-written
// sequences for back-to-back writes, timeout recovery, FIFO full and mid-cycle reset.
module tb_wb_seq_master;

  localparam logic [1:0] W = 2'd0, R = 2'd1, P = 2'd2, D = 2'd3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = '0;
  logic [1:0]  cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [31:0] cmd_msk_i = '0;
  logic        rsp_valid_o, rsp_err_o, busy_o, cyc_o, stb_o, wnr_o;
  logic [31:0] rsp_dat_o, dat_o;
  logic [1:0]  adr_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;

  always #5 clk = ~clk;

  wb_seq_master #(
    .AW(2), .DW(32), .DEPTH(8), .TIMEOUT(64), .POLL_MAX(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_msk_i(cmd_msk_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .wnr_o(wnr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model and bus/response monitor, all evaluated on the falling edge.
  int          cyc_n = 0;
  int          slv_lat = 0, slv_nzero = 0, slv_zcnt = 0;
  bit          slv_en = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          wcnt = 0, run = 0, run_start = 0, cyc_bad = 0;
  logic [1:0]  tx_adr[$];
  logic        tx_wnr[$];
  logic [31:0] tx_dat[$];
  int          run_len[$], run_beg[$];
  logic [31:0] rsp_d[$];
  logic        rsp_e[$];

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (cyc_o !== stb_o) cyc_bad++;
    if (rsp_valid_o) begin
      rsp_d.push_back(rsp_dat_o);
      rsp_e.push_back(rsp_err_o);
    end
    if (stb_o) begin
      if (run == 0) run_start = cyc_n;
      run++;
      if (slv_en && wcnt >= slv_lat) begin
        ack_i = 1'b1;
        if (slv_zcnt < slv_nzero) begin
          dat_i = '0;
          slv_zcnt++;
        end else begin
          dat_i = slv_rdata;
        end
        tx_adr.push_back(adr_o);
        tx_wnr.push_back(wnr_o);
        tx_dat.push_back(dat_o);
        wcnt = 0;
      end else begin
        ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      ack_i = 1'b0;
      dat_i = '0;
      wcnt  = 0;
      if (run > 0) begin
        run_len.push_back(run);
        run_beg.push_back(run_start);
        run = 0;
      end
    end
  end

  task automatic clear_logs();
    tx_adr.delete(); tx_wnr.delete(); tx_dat.delete();
    run_len.delete(); run_beg.delete(); rsp_d.delete(); rsp_e.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] adr,
                      input logic [31:0] dat, input logic [31:0] msk);
    bit done = 1'b0;
    cmd_op_i = op; cmd_adr_i = adr; cmd_dat_i = dat; cmd_msk_i = msk;
    cmd_valid_i = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (cmd_ready_o) done = 1'b1;
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    if (!done) chk("push_ready_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_rsp(input int n, input int bound);
    for (int k = 0; k < bound && rsp_d.size() < n; k++) @(negedge clk);
  endtask

  function automatic int bad_gaps();
    int b = 0;
    for (int k = 1; k < run_beg.size(); k++)
      if (run_beg[k] - (run_beg[k-1] + run_len[k-1]) != 1) b++;
    return b;
  endfunction

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [31:0] msk;
    int          lat;
    bit          ack_en;
    logic [31:0] rdata;
    int          nzero;
    int          exp_ntx;
    int          exp_nrun;
    int          exp_stb;
    logic [31:0] exp_rdat;
    logic        exp_err;
    logic        exp_wnr;
    logic [31:0] exp_wdat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] a;
    int          acc_n, bad;
    logic        acc[9];

    vecs[0]  = '{"wr_adr1",   W, 2'd1, 32'h3B,       32'h0,  2, 1, 32'h0,        0,    1,  1,  3, 32'h0,        1'b0, 1'b1, 32'h3B};
    vecs[1]  = '{"wr_adr0",   W, 2'd0, 32'h55555555, 32'h0,  2, 1, 32'h0,        0,    1,  1,  3, 32'h0,        1'b0, 1'b1, 32'h55555555};
    vecs[2]  = '{"rd_adr2",   R, 2'd2, 32'h0,        32'h0,  0, 1, 32'hAAAAAAAA, 0,    1,  1,  1, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{"poll_hit4", P, 2'd3, 32'h1,        32'h1,  0, 1, 32'h1,        3,    4,  4,  1, 32'h1,        1'b0, 1'b0, 32'h0};
    vecs[4]  = '{"poll_exh",  P, 2'd3, 32'h1,        32'h1,  0, 1, 32'h1,        1000, 16, 16, 1, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[5]  = '{"rd_tmo",    R, 2'd1, 32'h0,        32'h0,  0, 0, 32'h0,        0,    0,  1, 64, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[6]  = '{"dly3",      D, 2'd0, 32'h3,        32'h0,  0, 1, 32'h0,        0,    0,  0,  0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[7]  = '{"dly0",      D, 2'd0, 32'h0,        32'h0,  0, 1, 32'h0,        0,    0,  0,  0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"poll_msk",  P, 2'd0, 32'h50,       32'hF0, 1, 1, 32'h5A,       0,    1,  1,  2, 32'h5A,       1'b0, 1'b0, 32'h0};
    vecs[9]  = '{"rd_lat5",   R, 2'd1, 32'h0,        32'h0,  5, 1, 32'h12345678, 0,    1,  1,  6, 32'h12345678, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{"dly_hi",    D, 2'd2, 32'hFFFF0002, 32'h0,  0, 1, 32'h0,        0,    0,  0,  0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[11] = '{"poll_m0",   P, 2'd2, 32'hDEAD,     32'h0,  0, 1, 32'h77,       0,    1,  1,  1, 32'h77,       1'b0, 1'b0, 32'h0};

    // Reset values
    idle(3);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_wnr", 32'(wnr_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_rsp_dat", rsp_dat_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    rst_i = 1'b0;
    idle(2);

    // Table of single-command vectors
    for (int i = 0; i < 12; i++) begin
      clear_logs();
      slv_lat = vecs[i].lat; slv_en = vecs[i].ack_en; slv_rdata = vecs[i].rdata;
      slv_nzero = vecs[i].nzero; slv_zcnt = 0;
      push(vecs[i].op, vecs[i].adr, vecs[i].dat, vecs[i].msk);
      wait_rsp(1, 400);
      idle(4);
      chk({vecs[i].name, "_rsp_n"}, 32'(rsp_d.size()), 32'd1);
      a = (rsp_d.size() > 0) ? rsp_d[0] : 'x;
      chk({vecs[i].name, "_rsp_dat"}, a, vecs[i].exp_rdat);
      a = (rsp_e.size() > 0) ? 32'(rsp_e[0]) : 'x;
      chk({vecs[i].name, "_rsp_err"}, a, 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_ntx"}, 32'(tx_adr.size()), 32'(vecs[i].exp_ntx));
      chk({vecs[i].name, "_nrun"}, 32'(run_len.size()), 32'(vecs[i].exp_nrun));
      a = (run_len.size() > 0) ? 32'(run_len[run_len.size()-1]) : 32'd0;
      chk({vecs[i].name, "_stb_len"}, a, 32'(vecs[i].exp_stb));
      bad = 0;
      for (int k = 0; k < tx_adr.size(); k++)
        if (tx_adr[k] !== vecs[i].adr || tx_wnr[k] !== vecs[i].exp_wnr ||
            tx_dat[k] !== vecs[i].exp_wdat) bad++;
      chk({vecs[i].name, "_txn_fields"}, 32'(bad), 32'd0);
      chk({vecs[i].name, "_gaps"}, 32'(bad_gaps()), 32'd0);
      chk({vecs[i].name, "_busy_end"}, 32'(busy_o), 32'd0);
    end

    // Back-to-back writes with one idle strobe cycle between them
    clear_logs();
    slv_lat = 2; slv_en = 1'b1; slv_nzero = 0; slv_zcnt = 0;
    push(W, 2'd1, 32'h3B, 32'h0);
    push(W, 2'd0, 32'h55555555, 32'h0);
    wait_rsp(2, 200);
    idle(4);
    chk("b2b_rsp_n", 32'(rsp_d.size()), 32'd2);
    a = (rsp_e.size() > 1) ? 32'({rsp_e[0], rsp_e[1]}) : 'x;
    chk("b2b_rsp_err", a, 32'd0);
    a = (tx_adr.size() > 1) ? 32'({tx_adr[0], tx_adr[1]}) : 'x;
    chk("b2b_adr", a, 32'b0100);
    a = (tx_dat.size() > 0) ? tx_dat[0] : 'x;
    chk("b2b_dat0", a, 32'h3B);
    a = (tx_dat.size() > 1) ? tx_dat[1] : 'x;
    chk("b2b_dat1", a, 32'h55555555);
    a = (run_beg.size() > 1) ? 32'(run_beg[1] - run_beg[0] - run_len[0]) : 'x;
    chk("b2b_gap", a, 32'd1);

    // Timeout abandons the command, then the queued write runs
    clear_logs();
    slv_en = 1'b0; slv_lat = 0;
    push(R, 2'd2, 32'h0, 32'h0);
    push(W, 2'd1, 32'h0F, 32'h0);
    wait_rsp(1, 200);
    slv_en = 1'b1;
    wait_rsp(2, 200);
    idle(4);
    chk("tmo_rsp_n", 32'(rsp_d.size()), 32'd2);
    a = (rsp_e.size() > 1) ? 32'({rsp_e[0], rsp_e[1]}) : 'x;
    chk("tmo_rsp_err", a, 32'b10);
    a = (rsp_d.size() > 0) ? rsp_d[0] : 'x;
    chk("tmo_rsp_dat", a, 32'd0);
    a = (run_len.size() > 0) ? 32'(run_len[0]) : 'x;
    chk("tmo_stb_len", a, 32'd64);
    a = (tx_adr.size() == 1) ? 32'({tx_wnr[0], tx_adr[0]}) : 'x;
    chk("tmo_next_txn", a, 32'b101);

    // FIFO fills behind a stalled read; ninth push is refused
    clear_logs();
    slv_en = 1'b0; slv_lat = 0;
    push(R, 2'd3, 32'h0, 32'h0);
    idle(2);
    acc_n = 0;
    for (int i = 0; i < 9; i++) begin
      cmd_op_i = W; cmd_adr_i = 2'(i); cmd_dat_i = 32'(i); cmd_msk_i = '0;
      cmd_valid_i = 1'b1;
      acc[i] = cmd_ready_o;
      if (cmd_ready_o) acc_n++;
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    chk("full_accepted", 32'(acc_n), 32'd8);
    chk("full_9th_refused", 32'(acc[8]), 32'd0);
    chk("full_ready_low", 32'(cmd_ready_o), 32'd0);
    chk("full_busy", 32'(busy_o), 32'd1);
    slv_en = 1'b1;
    wait_rsp(9, 400);
    idle(4);
    chk("full_rsp_n", 32'(rsp_d.size()), 32'd9);
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (tx_dat.size() <= k + 1 || tx_dat[k+1] !== 32'(k) || tx_wnr[k+1] !== 1'b1) bad++;
    chk("full_order", 32'(bad), 32'd0);
    chk("full_ntx", 32'(tx_adr.size()), 32'd9);
    chk("full_ready_back", 32'(cmd_ready_o), 32'd1);

    // Reset while a strobe is outstanding and a command is queued
    clear_logs();
    slv_en = 1'b0;
    push(R, 2'd2, 32'h0, 32'h0);
    push(W, 2'd1, 32'hAB, 32'h0);
    idle(3);
    chk("rstmid_pre_stb", 32'(stb_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rstmid_stb", 32'(stb_o), 32'd0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_ready", 32'(cmd_ready_o), 32'd1);
    rst_i = 1'b0;
    slv_en = 1'b1;
    idle(20);
    chk("rstmid_no_rsp", 32'(rsp_d.size()), 32'd0);
    chk("rstmid_no_txn", 32'(tx_adr.size()), 32'd0);
    chk("rstmid_runs", 32'(run_len.size()), 32'd1);
    chk("cyc_eq_stb", 32'(cyc_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
